// File: rtl/result_packer_pipe.sv
// result_packer_pipe
//   Last FPU stage before writeback. Packs the final floating-point word from
//   operand fields, computed results or special constants. Applies overflow and
//   underflow overrides. Holds the packed beat in a 2-entry skid buffer behind a
//   valid/ready handshake, and accumulates sticky exception flags.
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   in_valid / in_ready           upstream handshake; in_ready is a pure state decode
//   sign/exponent/fraction_select field source selects
//   operand_* / result_*          candidate field values
//   out_valid / out_ready         downstream handshake
//   result                        packed {sign, exponent, fraction}
//   out_overflow / out_underflow  per-beat flags travelling with result
//   flags_clear                   clears sticky flags (a same-cycle set wins)
//   sticky_*                      accumulated exception flags
//
// Skid buffer states
//   state   | meaning
//   S_EMPTY | no beat held, out_valid=0
//   S_ONE   | head holds one beat
//   S_TWO   | head and tail full, in_ready=0
module result_packer_pipe #(
  parameter  int EXP_WIDTH  = 8,
  parameter  int FRAC_WIDTH = 23,
  localparam int WORD_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            sign_select,
  input  logic [2:0]            exponent_select,
  input  logic [2:0]            fraction_select,
  input  logic                  operand_sign_a,
  input  logic                  operand_sign_b,
  input  logic [EXP_WIDTH-1:0]  operand_exponent_a,
  input  logic [EXP_WIDTH-1:0]  operand_exponent_b,
  input  logic [FRAC_WIDTH-1:0] operand_fraction_a,
  input  logic [FRAC_WIDTH-1:0] operand_fraction_b,
  input  logic                  result_sign,
  input  logic [EXP_WIDTH+1:0]  result_exponent,
  input  logic [FRAC_WIDTH:0]   result_fraction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result,
  output logic                  out_overflow,
  output logic                  out_underflow,
  input  logic                  flags_clear,
  output logic                  sticky_overflow,
  output logic                  sticky_underflow,
  output logic                  sticky_invalid
);

  localparam logic [EXP_WIDTH+1:0] EXP_LIMIT = {2'b00, {EXP_WIDTH{1'b1}}};
  localparam int                   ENTRY_W   = WORD_WIDTH + 2;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  pk_sign;
  logic [EXP_WIDTH-1:0]  pk_exp;
  logic [FRAC_WIDTH-1:0] pk_frac;
  logic [FRAC_WIDTH-1:0] frac_mux;
  logic                  pk_ovf;
  logic                  pk_unf;
  logic                  exp_over;
  logic                  exp_nonpos;
  logic                  hidden_bit;

  logic [ENTRY_W-1:0]    pk_entry;
  logic [ENTRY_W-1:0]    head;
  logic [ENTRY_W-1:0]    tail;
  logic                  push;
  logic                  pop;

  // ---------------- field packing (combinational) ----------------
  assign exp_over   = $signed(result_exponent) >= $signed(EXP_LIMIT);
  assign exp_nonpos = result_exponent[EXP_WIDTH+1] | (result_exponent == '0);
  assign hidden_bit = result_fraction[FRAC_WIDTH];

  always_comb begin
    pk_sign = result_sign;
    case (sign_select)
      2'd0:    pk_sign = result_sign;
      2'd1:    pk_sign = operand_sign_a;
      2'd2:    pk_sign = operand_sign_b;
      default: pk_sign = ~result_sign;
    endcase
  end

  always_comb begin
    frac_mux = '0;
    case (fraction_select)
      3'd0:    frac_mux = result_fraction[FRAC_WIDTH-1:0];
      3'd1:    frac_mux = operand_fraction_a;
      3'd2:    frac_mux = operand_fraction_b;
      3'd3:    frac_mux = {1'b1, {(FRAC_WIDTH-1){1'b0}}};
      default: frac_mux = '0;
    endcase
  end

  // Only the computed exponent is range-checked; overflow saturates to
  // infinity and wins over the flush path, and a flush zeroes the fraction
  // regardless of fraction_select.
  always_comb begin
    pk_exp  = '0;
    pk_frac = frac_mux;
    pk_ovf  = 1'b0;
    pk_unf  = 1'b0;
    case (exponent_select)
      3'd0: begin
        if (exp_over) begin
          pk_exp  = '1;
          pk_frac = '0;
          pk_ovf  = 1'b1;
        end else if (exp_nonpos || !hidden_bit) begin
          pk_exp  = '0;
          pk_frac = '0;
          pk_unf  = exp_nonpos & hidden_bit;
        end else begin
          pk_exp  = result_exponent[EXP_WIDTH-1:0];
        end
      end
      3'd1:    pk_exp = operand_exponent_a;
      3'd2:    pk_exp = operand_exponent_b;
      3'd3:    pk_exp = '1;
      default: pk_exp = '0;
    endcase
  end

  assign pk_entry = {pk_ovf, pk_unf, pk_sign, pk_exp, pk_frac};

  // ---------------- skid buffer FSM ----------------
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_EMPTY;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY: if (push) state_next = S_ONE;
      S_ONE: begin
        if (push && !pop)      state_next = S_TWO;
        else if (!push && pop) state_next = S_EMPTY;
      end
      S_TWO:   if (pop) state_next = S_ONE;
      default: state_next = S_EMPTY;
    endcase
  end

  // Both handshake outputs decode registered state only, so in_ready never
  // has a combinational path from out_ready.
  always_comb begin
    out_valid = (state != S_EMPTY);
    in_ready  = (state != S_TWO);
  end

  // Data storage; head drives the outputs directly so they hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      case (state)
        S_EMPTY: if (push) head <= pk_entry;
        S_ONE: begin
          if (push && pop) head <= pk_entry;
          else if (push)   tail <= pk_entry;
        end
        S_TWO:   if (pop) head <= tail;
        default: ;
      endcase
    end
  end

  assign out_overflow  = head[ENTRY_W-1];
  assign out_underflow = head[ENTRY_W-2];
  assign result        = head[WORD_WIDTH-1:0];

  // ---------------- sticky flags ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_overflow  <= 1'b0;
      sticky_underflow <= 1'b0;
      sticky_invalid   <= 1'b0;
    end else begin
      sticky_overflow  <= (sticky_overflow  & ~flags_clear) | (push & pk_ovf);
      sticky_underflow <= (sticky_underflow & ~flags_clear) | (push & pk_unf);
      sticky_invalid   <= (sticky_invalid   & ~flags_clear) |
                          (push & (fraction_select == 3'd3));
    end
  end

endmodule

// File: tb/tb_result_packer_pipe.sv
module tb_result_packer_pipe;

  localparam int E = 8;
  localparam int F = 23;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sign_select;
  logic [2:0]  exponent_select;
  logic [2:0]  fraction_select;
  logic        operand_sign_a, operand_sign_b;
  logic [E-1:0] operand_exponent_a, operand_exponent_b;
  logic [F-1:0] operand_fraction_a, operand_fraction_b;
  logic        result_sign;
  logic [E+1:0] result_exponent;
  logic [F:0]   result_fraction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        out_overflow, out_underflow;
  logic        flags_clear;
  logic        sticky_overflow, sticky_underflow, sticky_invalid;

  result_packer_pipe #(.EXP_WIDTH(E), .FRAC_WIDTH(F)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_select(sign_select), .exponent_select(exponent_select),
    .fraction_select(fraction_select),
    .operand_sign_a(operand_sign_a), .operand_sign_b(operand_sign_b),
    .operand_exponent_a(operand_exponent_a), .operand_exponent_b(operand_exponent_b),
    .operand_fraction_a(operand_fraction_a), .operand_fraction_b(operand_fraction_b),
    .result_sign(result_sign), .result_exponent(result_exponent),
    .result_fraction(result_fraction),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_overflow(out_overflow), .out_underflow(out_underflow),
    .flags_clear(flags_clear),
    .sticky_overflow(sticky_overflow), .sticky_underflow(sticky_underflow),
    .sticky_invalid(sticky_invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] word;
    logic        ovf;
    logic        unf;
  } beat_t;

  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  st_ovf = 1'b0, st_unf = 1'b0, st_inv = 1'b0;

  task automatic chk1(input string nm, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, got, want, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: integer arithmetic on the field rules, applied to current inputs.
  function automatic beat_t model_now();
    beat_t b;
    int re, s, e, f, hid;
    re  = int'(result_exponent);
    if (re >= (1 << (E + 1))) re -= (1 << (E + 2));
    hid = int'(result_fraction) >> F;
    case (sign_select)
      2'd0:    s = int'(result_sign);
      2'd1:    s = int'(operand_sign_a);
      2'd2:    s = int'(operand_sign_b);
      default: s = 1 - int'(result_sign);
    endcase
    case (fraction_select)
      3'd0:    f = int'(result_fraction) % (1 << F);
      3'd1:    f = int'(operand_fraction_a);
      3'd2:    f = int'(operand_fraction_b);
      3'd3:    f = 1 << (F - 1);
      default: f = 0;
    endcase
    b.ovf = 1'b0;
    b.unf = 1'b0;
    case (exponent_select)
      3'd0: begin
        if (re >= (1 << E) - 1) begin
          e = (1 << E) - 1; f = 0; b.ovf = 1'b1;
        end else if (re <= 0 || hid == 0) begin
          e = 0; f = 0; b.unf = (re <= 0 && hid == 1);
        end else begin
          e = re;
        end
      end
      3'd1:    e = int'(operand_exponent_a);
      3'd2:    e = int'(operand_exponent_b);
      3'd3:    e = (1 << E) - 1;
      default: e = 0;
    endcase
    b.word = {1'(s), 8'(e), 23'(f)};
    return b;
  endfunction

  // Scoreboard monitor: samples on the falling edge, where inputs and outputs
  // are both settled for the next rising edge.
  always @(negedge clk) begin
    beat_t nb;
    logic  acc;
    if (!reset_n) begin
      sb.delete();
      st_ovf = 1'b0; st_unf = 1'b0; st_inv = 1'b0;
    end else begin
      chk1("out_valid", out_valid, sb.size() > 0);
      chk1("in_ready", in_ready, sb.size() < 2);
      if (out_valid && sb.size() > 0) begin
        chk32("result", result, sb[0].word);
        chk1("out_overflow", out_overflow, sb[0].ovf);
        chk1("out_underflow", out_underflow, sb[0].unf);
      end
      chk1("sticky_overflow", sticky_overflow, st_ovf);
      chk1("sticky_underflow", sticky_underflow, st_unf);
      chk1("sticky_invalid", sticky_invalid, st_inv);
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      acc = in_valid & in_ready;
      nb  = model_now();
      if (acc) sb.push_back(nb);
      st_ovf = (st_ovf & ~flags_clear) | (acc & nb.ovf);
      st_unf = (st_unf & ~flags_clear) | (acc & nb.unf);
      st_inv = (st_inv & ~flags_clear) | (acc & (fraction_select == 3'd3));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic zero_fields();
    sign_select = 2'd0; exponent_select = 3'd0; fraction_select = 3'd0;
    operand_sign_a = 1'b0; operand_sign_b = 1'b0;
    operand_exponent_a = '0; operand_exponent_b = '0;
    operand_fraction_a = '0; operand_fraction_b = '0;
    result_sign = 1'b0; result_exponent = '0; result_fraction = '0;
  endtask

  task automatic rand_fields();
    sign_select     = 2'($urandom_range(0, 3));
    exponent_select = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 7));
    fraction_select = (exponent_select == 3'd0) ? 3'd0 : 3'($urandom_range(0, 7));
    operand_sign_a     = 1'($urandom);
    operand_sign_b     = 1'($urandom);
    operand_exponent_a = 8'($urandom);
    operand_exponent_b = 8'($urandom);
    operand_fraction_a = 23'($urandom);
    operand_fraction_b = 23'($urandom);
    result_sign        = 1'($urandom);
    case ($urandom_range(0, 3))
      0: result_exponent = 10'($urandom);
      1: case ($urandom_range(0, 7))
           0: result_exponent = 10'd0;
           1: result_exponent = 10'd1;
           2: result_exponent = 10'd254;
           3: result_exponent = 10'd255;
           4: result_exponent = 10'd256;
           5: result_exponent = 10'h1FF;
           6: result_exponent = 10'h200;
           default: result_exponent = 10'h3FF;
         endcase
      default: result_exponent = 10'($urandom_range(1, 254));
    endcase
    result_fraction = {($urandom_range(0, 3) != 0), 23'($urandom)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clear = 1'b0;
    zero_fields();
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk32("rst_result", result, 32'h0);
    chk1("rst_ovf", out_overflow, 1'b0);
    chk1("rst_unf", out_underflow, 1'b0);
    chk1("rst_sticky_ovf", sticky_overflow, 1'b0);
    chk1("rst_sticky_inv", sticky_invalid, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // normal pack
    result_exponent = 10'd127; result_fraction = {1'b1, 23'h400000};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t1_valid", out_valid, 1'b1);
    chk32("t1_result", result, 32'h3FC00000);
    chk1("t1_ovf", out_overflow, 1'b0);
    chk1("t1_unf", out_underflow, 1'b0);

    // overflow, then clear racing a new overflow, then plain clear
    result_exponent = 10'd255;
    in_valid = 1'b1;
    tick();
    chk32("t2_result", result, 32'h7F800000);
    chk1("t2_ovf", out_overflow, 1'b1);
    chk1("t2_sticky", sticky_overflow, 1'b1);
    flags_clear = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t2_set_wins", sticky_overflow, 1'b1);
    tick();
    flags_clear = 1'b0;
    chk1("t2_cleared", sticky_overflow, 1'b0);

    // underflow with sign from operand A
    zero_fields();
    result_exponent = 10'h3FD; result_fraction = {1'b1, 23'h123456};
    sign_select = 2'd1; operand_sign_a = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk32("t3_result", result, 32'h80000000);
    chk1("t3_unf", out_underflow, 1'b1);
    chk1("t3_sticky_unf", sticky_underflow, 1'b1);

    // hidden bit clear: flush without underflow flag
    zero_fields();
    result_exponent = 10'd100; result_fraction = {1'b0, 23'h7FFFFF};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk32("t3b_result", result, 32'h0);
    chk1("t3b_unf", out_underflow, 1'b0);

    // quiet NaN
    zero_fields();
    exponent_select = 3'd3; fraction_select = 3'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk32("t4_result", result, 32'h7FC00000);
    chk1("t4_sticky_inv", sticky_invalid, 1'b1);
    tick();

    // backpressure: three beats offered, two taken
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      zero_fields();
      exponent_select = 3'd1; fraction_select = 3'd1;
      operand_exponent_a = 8'(i + 1); operand_fraction_a = 23'(i * 7 + 3);
      in_valid = 1'b1;
      if (in_ready) accepted++;
      tick();
    end
    chk32("bp_accepted", 32'(accepted), 32'd2);
    chk1("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    begin
      int k;
      k = 0;
      while (!in_ready && k < 10) begin tick(); k++; end
      chk1("bp_third_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      k = 0;
      while (out_valid && k < 10) begin tick(); k++; end
      chk1("bp_drained", out_valid, 1'b0);
    end

    // reset with two beats buffered
    out_ready = 1'b0;
    zero_fields();
    exponent_select = 3'd2; operand_exponent_b = 8'h55;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk1("rb_full_valid", out_valid, 1'b1);
    chk1("rb_full_ready", in_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk1("rb_out_valid", out_valid, 1'b0);
    chk1("rb_in_ready", in_ready, 1'b1);
    chk32("rb_result", result, 32'h0);
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    zero_fields();
    result_exponent = 10'd127; result_fraction = {1'b1, 23'h400000};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("rb_latency_valid", out_valid, 1'b1);
    chk32("rb_latency_result", result, 32'h3FC00000);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_fields();
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      flags_clear = ($urandom_range(0, 9) == 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; flags_clear = 1'b0;
    begin
      int k;
      k = 0;
      while (out_valid && k < 10) begin tick(); k++; end
    end
    tick();
    chk1("final_empty", out_valid, 1'b0);
    chk32("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
